// File: rtl/board_ram_arbiter.sv
// Board RAM arbiter: 256-cycle board clear, plus round-robin game/display access; accepted request drives RAM next cycle, read data returns one cycle later.
// Requesters hold req until ack; requests wait while the clear runs and are accepted on its final edge or later.
module board_ram_arbiter #(
  parameter logic [3:0] EMPTY_CODE = 4'd14,
  parameter logic [7:0] HEAD_ADDR  = 8'd152,
  parameter logic [3:0] HEAD_CODE  = 4'd0,
  parameter logic [7:0] FOOD_ADDR  = 8'd136,
  parameter logic [3:0] FOOD_CODE  = 4'd6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_start,
  output logic       busy,
  input  logic       g_req,
  input  logic       g_we,
  input  logic [7:0] g_addr,
  input  logic [3:0] g_wdata,
  output logic       g_ack,
  output logic       g_rvalid,
  output logic [3:0] g_rdata,
  input  logic       d_req,
  input  logic [7:0] d_addr,
  output logic       d_ack,
  output logic       d_rvalid,
  output logic [3:0] d_rdata,
  output logic       ram_we,
  output logic [7:0] ram_addr,
  output logic [3:0] ram_din,
  input  logic [3:0] ram_dout
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       we_q, we_nxt;
  logic [7:0] addr_q, addr_nxt;
  logic [3:0] din_q, din_nxt;
  logic       g_ack_q, g_ack_nxt, d_ack_q, d_ack_nxt;
  logic       g_pend, g_pend_nxt, d_pend, d_pend_nxt;
  logic       g_rv_q, d_rv_q;
  logic [3:0] g_rd_q, d_rd_q;
  logic       last_d, last_d_nxt;
  logic       arb_en;
  logic       g_ok, d_ok, grant_g, grant_d;

  function automatic logic [3:0] cell_code(input logic [7:0] a);
    if (a == HEAD_ADDR)      return HEAD_CODE;
    else if (a == FOOD_ADDR) return FOOD_CODE;
    else                     return EMPTY_CODE;
  endfunction

  // A port is masked in its ack cycle: its req is still the request just accepted.
  assign g_ok    = g_req & ~g_ack_q;
  assign d_ok    = d_req & ~d_ack_q;
  assign grant_d = d_ok & (~g_ok | ~last_d);
  assign grant_g = g_ok & ~grant_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    we_nxt     = 1'b0;
    addr_nxt   = addr_q;
    din_nxt    = din_q;
    g_ack_nxt  = 1'b0;
    d_ack_nxt  = 1'b0;
    g_pend_nxt = 1'b0;
    d_pend_nxt = 1'b0;
    last_d_nxt = last_d;
    arb_en     = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt = CLEAR;
          cnt_nxt   = 8'd0;
          we_nxt    = 1'b1;
          addr_nxt  = 8'd0;
          din_nxt   = cell_code(8'd0);
        end else begin
          arb_en = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt == 8'hFF) begin
          state_nxt = IDLE;
          arb_en    = 1'b1;
        end else begin
          cnt_nxt  = cnt + 8'd1;
          we_nxt   = 1'b1;
          addr_nxt = cnt + 8'd1;
          din_nxt  = cell_code(cnt + 8'd1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (arb_en && grant_g) begin
      g_ack_nxt  = 1'b1;
      we_nxt     = g_we;
      addr_nxt   = g_addr;
      din_nxt    = g_wdata;
      g_pend_nxt = ~g_we;
      last_d_nxt = 1'b0;
    end else if (arb_en && grant_d) begin
      d_ack_nxt  = 1'b1;
      addr_nxt   = d_addr;
      d_pend_nxt = 1'b1;
      last_d_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= 8'd0;
      din_q   <= 4'd0;
      g_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      g_pend  <= 1'b0;
      d_pend  <= 1'b0;
      g_rv_q  <= 1'b0;
      d_rv_q  <= 1'b0;
      g_rd_q  <= 4'd0;
      d_rd_q  <= 4'd0;
      last_d  <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      we_q    <= we_nxt;
      addr_q  <= addr_nxt;
      din_q   <= din_nxt;
      g_ack_q <= g_ack_nxt;
      d_ack_q <= d_ack_nxt;
      g_pend  <= g_pend_nxt;
      d_pend  <= d_pend_nxt;
      g_rv_q  <= g_pend;
      d_rv_q  <= d_pend;
      last_d  <= last_d_nxt;
      if (g_rv_q) g_rd_q <= ram_dout;
      if (d_rv_q) d_rd_q <= ram_dout;
    end
  end

  // Read data is presented straight from the RAM in the valid cycle, then held.
  assign g_rdata  = g_rv_q ? ram_dout : g_rd_q;
  assign d_rdata  = d_rv_q ? ram_dout : d_rd_q;
  assign g_rvalid = g_rv_q;
  assign d_rvalid = d_rv_q;
  assign g_ack    = g_ack_q;
  assign d_ack    = d_ack_q;
  assign busy     = (state == CLEAR);
  assign ram_we   = we_q;
  assign ram_addr = addr_q;
  assign ram_din  = din_q;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Scoreboard bench for board_ram_arbiter: directed accesses and clears against a registered-read RAM model.
module tb_board_ram_arbiter;

  localparam logic [7:0] PG = 8'd71;
  localparam logic [7:0] PD = 8'd68;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr_start = 1'b0;
  logic       busy;
  logic       g_req = 1'b0, g_we = 1'b0;
  logic [7:0] g_addr = 8'd0;
  logic [3:0] g_wdata = 4'd0;
  logic       g_ack, g_rvalid;
  logic [3:0] g_rdata;
  logic       d_req = 1'b0;
  logic [7:0] d_addr = 8'd0;
  logic       d_ack, d_rvalid;
  logic [3:0] d_rdata;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [3:0] ram_din;
  logic [3:0] ram_dout = 4'd0;

  logic [3:0] mem [0:255] = '{default: 4'hA};

  logic [7:0] ack_q [$];
  logic [3:0] grd_q [$];
  logic [3:0] drd_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  board_ram_arbiter dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .busy(busy),
    .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
    .g_ack(g_ack), .g_rvalid(g_rvalid), .g_rdata(g_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_ack(input logic [7:0] who);
    if (ack_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL ack_unexpected: got ack from %c, none expected", who);
    end else begin
      chk("ack_order", int'(who), int'(ack_q.pop_front()));
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an ack or read data.
  int mcyc = 0, g_ack_cyc = -10, d_ack_cyc = -10;
  logic [3:0] g_hold = 4'd0, d_hold = 4'd0;
  always @(negedge clk) begin
    mcyc++;
    if (!rst) begin
      g_hold = 4'd0;
      d_hold = 4'd0;
    end else begin
      if (g_ack || d_ack) begin
        chk("ack_while_busy", int'(busy), 0);
        chk("single_ack", int'(g_ack & d_ack), 0);
      end
      if (g_ack) begin g_ack_cyc = mcyc; pop_ack(PG); end
      if (d_ack) begin d_ack_cyc = mcyc; pop_ack(PD); end
      if (g_rvalid) begin
        chk("g_rvalid_latency", mcyc - g_ack_cyc, 1);
        if (grd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL g_rvalid_unexpected: got data %0d, none expected", g_rdata);
        end else chk("g_rdata", int'(g_rdata), int'(grd_q.pop_front()));
        g_hold = g_rdata;
      end else chk("g_rdata_hold", int'(g_rdata), int'(g_hold));
      if (d_rvalid) begin
        chk("d_rvalid_latency", mcyc - d_ack_cyc, 1);
        if (drd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_rvalid_unexpected: got data %0d, none expected", d_rdata);
        end else chk("d_rdata", int'(d_rdata), int'(drd_q.pop_front()));
        d_hold = d_rdata;
      end else chk("d_rdata_hold", int'(d_rdata), int'(d_hold));
    end
  end

  task automatic g_access(input logic we, input logic [7:0] a, input logic [3:0] wd,
                          input logic [3:0] exp_rd, input int budget, output int lat);
    if (!we) grd_q.push_back(exp_rd);
    g_we = we; g_addr = a; g_wdata = wd; g_req = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!g_ack && lat < budget);
    chk("g_ack_seen", int'(g_ack), 1);
    g_req = 1'b0;
  endtask

  task automatic d_access(input logic [7:0] a, input logic [3:0] exp_rd,
                          input int budget, output int lat);
    drd_q.push_back(exp_rd);
    d_addr = a; d_req = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!d_ack && lat < budget);
    chk("d_ack_seen", int'(d_ack), 1);
    d_req = 1'b0;
  endtask

  // Pulses clr_start, optionally re-pulses it after rp busy cycles, returns busy-cycle count.
  task automatic count_busy(input int rp, output int n);
    clr_start = 1'b1;
    n = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (busy) n++;
      else if (n > 0 || k > 2) break;
      clr_start = (n == rp);
    end
    clr_start = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat, bad;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_ram_din", int'(ram_din), 0);
    chk("rst_ack_rvalid", int'({g_ack, d_ack, g_rvalid, d_rvalid}), 0);
    chk("rst_rdata", int'({g_rdata, d_rdata}), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Both requesters held high from reset: display wins first tie, then alternation.
    ack_q = '{PD, PG, PD, PG, PD, PG};
    drd_q = '{4'hA, 4'hA, 4'hA};
    g_we = 1'b1; g_addr = 8'd50; g_wdata = 4'd5; d_addr = 8'd10;
    g_req = 1'b1; d_req = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    g_req = 1'b0; d_req = 1'b0;
    settle();
    chk("rr_cell50_written", int'(mem[50]), 5);
    chk("rr_acks_drained", ack_q.size(), 0);

    // Reset in clear cycle 100 aborts the clear.
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    n = 0;
    while (ram_addr != 8'd100 && n < 300) begin @(posedge clk); #1; n++; end
    chk("abort_at_addr100", int'(ram_addr), 100);
    rst = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_ram_we", int'(ram_we), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) if (mem[i] != 4'd14) bad++;
    chk("abort_low_cells_cleared", bad, 0);
    bad = 0;
    for (int i = 100; i < 256; i++) if (mem[i] != 4'hA) bad++;
    chk("abort_high_cells_untouched", bad, 0);

    // Full clear with an ignored second clr_start mid-way.
    count_busy(50, n);
    chk("clear_busy_cycles", n, 256);
    chk("cell152_head", int'(mem[152]), 0);
    chk("cell136_food", int'(mem[136]), 6);
    bad = 0;
    for (int i = 0; i < 256; i++) if (i != 152 && i != 136 && mem[i] != 4'd14) bad++;
    chk("cells_empty", bad, 0);
    settle();

    // Lone game read of the head cell.
    ack_q.push_back(PG);
    g_access(1'b0, 8'd152, 4'd0, 4'd0, 20, lat);
    chk("g_ack_latency", lat, 1);
    settle();

    // Game write then display read of the same cell.
    ack_q.push_back(PG);
    g_access(1'b1, 8'd40, 4'd3, 4'd0, 20, lat);
    ack_q.push_back(PD);
    d_access(8'd40, 4'd3, 20, lat);
    settle();

    // Tie after a display grant: game wins.
    ack_q.push_back(PG);
    ack_q.push_back(PD);
    fork
      begin int l1; g_access(1'b0, 8'd136, 4'd0, 4'd6, 20, l1); end
      begin int l2; d_access(8'd152, 4'd0, 20, l2); end
    join
    settle();

    // Read accepted the cycle before a clear still returns its data.
    ack_q.push_back(PG);
    g_access(1'b0, 8'd136, 4'd0, 4'd6, 20, lat);
    count_busy(0, n);
    chk("clear_after_read_busy", n, 256);
    settle();

    // clr_start coincident with a display request.
    ack_q.push_back(PD);
    fork
      begin int l3; d_access(8'd136, 4'd6, 400, l3); end
      begin
        int nb;
        count_busy(0, nb);
        chk("coinc_busy_cycles", nb, 256);
        chk("coinc_dack_when_busy_falls", int'(d_ack), 1);
      end
    join
    settle();

    chk("ack_queue_empty", ack_q.size(), 0);
    chk("grd_queue_empty", grd_q.size(), 0);
    chk("drd_queue_empty", drd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_ram_arbiter.md
BOARD_RAM_ARBITER -- requirements
Module: board_ram_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- EMPTY_CODE, 14, cell code written by clear sequence.
- HEAD_ADDR, 152, snake-head cell address.
- HEAD_CODE, 0, code written at HEAD_ADDR.
- FOOD_ADDR, 136, initial food cell address.
- FOOD_CODE, 6, code written at FOOD_ADDR.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, reset, asynchronous, active-low.
- clr_start, in, 1, pulse: start board clear.
- busy, out, 1, high while clear runs.
- g_req, in, 1, game-logic access request.
- g_we, in, 1, game write (1) / read (0).
- g_addr, in, 8, game cell address.
- g_wdata, in, 4, game write data.
- g_ack, out, 1, one-cycle pulse: game request accepted.
- g_rvalid, out, 1, one-cycle pulse: g_rdata valid.
- g_rdata, out, 4, game read data.
- d_req, in, 1, display read request.
- d_addr, in, 8, display cell address.
- d_ack, out, 1, one-cycle pulse: display request accepted.
- d_rvalid, out, 1, one-cycle pulse: d_rdata valid.
- d_rdata, out, 4, display read data.
- ram_we, out, 1, RAM write enable.
- ram_addr, out, 8, RAM address.
- ram_din, out, 4, RAM write data.
- ram_dout, in, 4, RAM registered read data, valid one cycle after a non-write address cycle.

Function
REQ-003 FSM states SHALL be IDLE and CLEAR; CLEAR is entered only from IDLE on clr_start=1 and exits to IDLE after the cycle issuing address 255.
REQ-004 In CLEAR, ram_we=1 each cycle, ram_addr counts 0..255 (8-bit counter, one address per cycle, 256 cycles total); ram_din=HEAD_CODE at HEAD_ADDR, FOOD_CODE at FOOD_ADDR, else EMPTY_CODE.
REQ-005 busy SHALL be 1 exactly during the 256 CLEAR cycles; no g_ack/d_ack is issued during CLEAR.
REQ-006 clr_start while in CLEAR SHALL be ignored (no restart).
REQ-007 In IDLE, a request is accepted at a clock edge where its req=1; accept is registered: ram_we/ram_addr/ram_din driven from the accepted request in the following cycle (A+1); ack pulses in that same cycle.
REQ-008 Requesters SHALL hold req/addr/we/wdata stable until ack; the arbiter samples them only on the accepting edge.
REQ-009 If only one req is high, it is accepted; if both are high, the requester not granted most recently wins (round-robin); the last-granted pointer resets to game, so display wins the first tie.
REQ-010 At most one request is accepted per cycle; a sustained pair of requests SHALL alternate D,G,D,G,...
REQ-011 Reads: ram_we=0 in A+1, ram_dout sampled in A+2, rvalid of the owning port pulses in A+2 with rdata=ram_dout; other port's rvalid stays 0.
REQ-012 Writes: ram_we=1 in A+1 only; no rvalid is generated.
REQ-013 In cycles with no accepted request and not CLEAR, ram_we=0 and ram_addr holds its last value.
REQ-014 clr_start arriving in the same cycle as a req SHALL take priority; the req stays pending and is accepted after CLEAR ends; a read accepted the cycle before CLEAR still returns its rvalid in A+2.
REQ-015 g_rdata/d_rdata SHALL hold their last value between rvalid pulses.

Reset
REQ-016 rst=0 SHALL immediately force: state IDLE, counter 0, busy 0, ram_we 0, ram_addr 0, ram_din 0, all ack/rvalid 0, rdata 0, last-granted = game, in-flight reads discarded.
REQ-017 Reset does not initiate a clear; the game controller pulses clr_start after reset release.
REQ-018 rst asserted mid-CLEAR SHALL abort the clear; cells already written remain written.

Verification
REQ-019 clr_start pulse from IDLE -> busy high 256 cycles; RAM model shows cell 152=0, 136=6, all others 14; no acks during busy.
REQ-020 g_req read addr 152 alone after clear -> g_ack at A+1, g_rvalid at A+2 with g_rdata=0; d_rvalid stays 0.
REQ-021 g_req write addr 40 data 3, then d_req read addr 40 -> d_rdata=3.
REQ-022 g_req and d_req held high 6 cycles from reset -> acks in order D,G,D,G,D,G.
REQ-023 clr_start coincident with d_req -> busy 256 cycles, d_ack in first cycle after busy falls.
REQ-024 rst=0 at clear cycle 100 -> busy 0 and ram_we 0 asynchronously; cells 0..99 cleared, 100..255 untouched.
